seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_div_step.sv | 29 ++
 rtl/seq_divider.sv | 194 +++++++++++++++++++
 tb/tb_seq_divider.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding,
// operation opcodes and the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Opcodes recorded at start so later stages know which flavour of divide runs.
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] DIV  = 6'b011010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left by one,
// trial-subtract the divisor and keep the difference when it does not go negative.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // One extra bit holds the bit shifted out of rem; with a non-zero divisor the
  // partial remainder stays below the divisor, so bit WIDTH of the difference is
  // a reliable sign bit.
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign w_fits    = ~w_diff[WIDTH];

  assign o_rem = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider. Operands are converted to magnitudes at
// start, divided by WIDTH restoring steps, sign-corrected, then published as
// {remainder, quotient} together with a one-cycle done pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] dataOut
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};

  // Two's-complement negation within the operand width.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [5:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_zero;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_res_q;
  logic [WIDTH-1:0]   r_res_r;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [2*WIDTH-1:0] r_data_out;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic               w_mode_signed;

  // Magnitudes only differ from the raw operands for negative signed inputs;
  // the most negative value maps to itself, which is its correct unsigned magnitude.
  assign w_a_mag = (is_signed && dataA[WIDTH-1]) ? neg(dataA) : dataA;
  assign w_b_mag = (is_signed && dataB[WIDTH-1]) ? neg(dataB) : dataB;
  assign w_mode_signed = (r_op == DIV);

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_step_rem),
    .o_quo    (w_step_quo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: RUN lasts WIDTH cycles, FIX and DONE one cycle each.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_next_state = FIX;
        end else begin
          w_next_state = RUN;
        end
      end
      FIX:     w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: latch operands on start, iterate in RUN, sign-correct in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= CNT_ZERO;
      r_op       <= DIVU;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_dividend <= ZERO_W;
      r_divisor  <= ZERO_W;
      r_rem      <= ZERO_W;
      r_quo      <= ZERO_W;
      r_res_q    <= ZERO_W;
      r_res_r    <= ZERO_W;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt      <= CNT_ZERO;
            r_op       <= is_signed ? DIV : DIVU;
            r_neg_q    <= dataA[WIDTH-1] ^ dataB[WIDTH-1];
            r_neg_r    <= dataA[WIDTH-1];
            r_zero     <= (dataB == ZERO_W);
            r_dividend <= dataA;
            r_divisor  <= w_b_mag;
            r_rem      <= ZERO_W;
            r_quo      <= w_a_mag;
          end
        end
        RUN: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt + CNT_ONE;
        end
        FIX: begin
          if (r_zero) begin
            // A zero divisor returns all-ones and the untouched dividend.
            r_res_q <= ONES_W;
            r_res_r <= r_dividend;
          end else begin
            r_res_q <= (w_mode_signed && r_neg_q) ? neg(r_quo) : r_quo;
            r_res_r <= (w_mode_signed && r_neg_r) ? neg(r_rem) : r_rem;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered status and result; dataOut only changes when a result is published.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_data_out <= {(2*WIDTH){1'b0}};
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
          end else begin
            r_busy <= r_busy;
          end
        end
        DONE: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_dbz      <= r_zero;
          r_data_out <= {r_res_r, r_res_q};
        end
        default: begin
          r_busy <= r_busy;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign dataOut     = r_data_out;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=32 and WIDTH=16: directed cases with literal
// expectations plus randomized traffic checked every cycle against an
// arithmetic reference model.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        st[2];
  logic        sg[2];
  logic [31:0] da[2];
  logic [31:0] db[2];

  logic        busy0, done0, dbz0;
  logic [63:0] out0;
  logic        busy1, done1, dbz1;
  logic [31:0] out1;

  logic        busy_w[2], done_w[2], dbz_w[2];
  logic [63:0] out_w[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0[2];

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(st[0]), .is_signed(sg[0]),
    .dataA(da[0]), .dataB(db[0]), .busy(busy0), .done(done0),
    .div_by_zero(dbz0), .dataOut(out0)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(st[1]), .is_signed(sg[1]),
    .dataA(da[1][15:0]), .dataB(db[1][15:0]), .busy(busy1), .done(done1),
    .div_by_zero(dbz1), .dataOut(out1)
  );

  assign busy_w[0] = busy0;
  assign done_w[0] = done0;
  assign dbz_w[0]  = dbz0;
  assign out_w[0]  = out0;
  assign busy_w[1] = busy1;
  assign done_w[1] = done1;
  assign dbz_w[1]  = dbz1;
  assign out_w[1]  = {32'd0, out1};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  // Reference divide with plain integer arithmetic; returns {rem, quo} packed at width w.
  function automatic logic [63:0] ref_div(input int w, input logic s, input logic [31:0] a,
                                          input logic [31:0] b, output logic z);
    longint m, la, lb, sa, sb, q, r;
    m  = (longint'(1) << w) - 1;
    la = longint'({32'd0, a}) & m;
    lb = longint'({32'd0, b}) & m;
    z  = (lb == 0);
    if (z) begin
      q = m;
      r = la;
    end else if (s) begin
      sa = la[w-1] ? la - (longint'(1) << w) : la;
      sb = lb[w-1] ? lb - (longint'(1) << w) : lb;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = la / lb;
      r = la % lb;
    end
    q = q & m;
    r = r & m;
    return (64'(r) << w) | 64'(q);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    int k;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    k = $urandom_range(0, 9);
    case (k)
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3, 4:    return 32'($urandom_range(0, 20));
      5:       return m - 32'($urandom_range(0, 20));
      default: return $urandom & m;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model and per-cycle compare against both instances.
  int          m_cnt[2];
  logic        m_busy[2], m_done[2], m_dbz[2], m_pz[2];
  logic [63:0] m_out[2], m_pend[2];
  bit          m_init = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          m_cnt[d] = 0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
          m_dbz[d] = 1'b0; m_out[d] = 64'd0;
        end else begin
          m_done[d] = 1'b0;
          m_dbz[d]  = 1'b0;
          if (m_cnt[d] > 0) begin
            m_cnt[d]--;
            if (m_cnt[d] == 0) begin
              m_done[d] = 1'b1;
              m_busy[d] = 1'b0;
              m_out[d]  = m_pend[d];
              m_dbz[d]  = m_pz[d];
            end
          end else if (st[d]) begin
            m_pend[d] = ref_div(wid(d), sg[d], da[d], db[d], m_pz[d]);
            m_cnt[d]  = wid(d) + 2;
            m_busy[d] = 1'b1;
          end
        end
      end
      if (reset) m_init = 1'b1;
      #1;
      if (m_init) begin
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if ({busy_w[d], done_w[d], dbz_w[d]} !== {m_busy[d], m_done[d], m_dbz[d]} ||
              out_w[d] !== m_out[d]) begin
            n_fail++;
            $display("FAIL model_cmp w%0d t=%0t: got busy=%b done=%b dbz=%b out=%h, expected busy=%b done=%b dbz=%b out=%h",
                     wid(d), $time, busy_w[d], done_w[d], dbz_w[d], out_w[d],
                     m_busy[d], m_done[d], m_dbz[d], m_out[d]);
          end
        end
      end
    end
  end

  task automatic launch(input int d, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    st[d] = 1'b1; sg[d] = s; da[d] = a; db[d] = b;
    @(posedge clk);
    #1;
    t0[d] = cyc;
    @(negedge clk);
    st[d] = 1'b0; sg[d] = ~s; da[d] = $urandom; db[d] = $urandom;
  endtask

  task automatic await_done(input int d, input logic [63:0] e, input logic z, input string name);
    int  w;
    bit  seen;
    w    = wid(d);
    seen = 1'b0;
    for (int i = 0; i < w + 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done_w[d]) begin
        seen = 1'b1;
        chk({name, "_data"}, out_w[d], e);
        chk({name, "_dbz"}, 64'(dbz_w[d]), 64'(z));
        chk({name, "_latency"}, 64'(cyc - t0[d]), 64'(w + 2));
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, w + 8);
    end
  endtask

  typedef struct {
    string       nm;
    logic        s;
    logic [31:0] a32, b32;
    logic [63:0] e32;
    logic [31:0] a16, b16;
    logic [63:0] e16;
    logic        z;
  } case_t;

  case_t tbl[9];

  initial begin
    logic        zz;
    int          nd;
    logic [63:0] ev;

    tbl[0] = '{"u100_7",   1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},
               32'd100,        32'd7,        {32'd0, 16'd2, 16'd14},        1'b0};
    tbl[1] = '{"sm7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD},
               32'h0000_FFF9,  32'd2,        {32'd0, 16'hFFFF, 16'hFFFD},   1'b0};
    tbl[2] = '{"s7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD},
               32'd7,          32'h0000_FFFE, {32'd0, 16'h0001, 16'hFFFD},  1'b0};
    tbl[3] = '{"u_div0",   1'b0, 32'h1234_5678,  32'd0,        {32'h1234_5678, 32'hFFFF_FFFF},
               32'h0000_1234,  32'd0,        {32'd0, 16'h1234, 16'hFFFF},   1'b1};
    tbl[4] = '{"s_div0",   1'b1, 32'hFFFF_FF00,  32'd0,        {32'hFFFF_FF00, 32'hFFFF_FFFF},
               32'h0000_FF00,  32'd0,        {32'd0, 16'hFF00, 16'hFFFF},   1'b1};
    tbl[5] = '{"s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000},
               32'h0000_8000,  32'h0000_FFFF, {32'd0, 16'h0000, 16'h8000},  1'b0};
    tbl[6] = '{"u_ovfops", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000},
               32'h0000_8000,  32'h0000_FFFF, {32'd0, 16'h8000, 16'h0000},  1'b0};
    tbl[7] = '{"sm100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,        {32'hFFFF_FFFE, 32'hFFFF_FFF2},
               32'h0000_FF9C,  32'd7,        {32'd0, 16'hFFFE, 16'hFFF2},   1'b0};
    tbl[8] = '{"u_max_10", 1'b0, 32'hFFFF_FFFF,  32'd10,       {32'd5, 32'h1999_9999},
               32'h0000_FFFF,  32'd10,       {32'd0, 16'd5, 16'h1999},      1'b0};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; sg[d] = 1'b0; da[d] = 32'd0; db[d] = 32'd0; t0[d] = 0;
    end

    // Pin the reference model to hand-computed results.
    for (int i = 0; i < 9; i++) begin
      chk({"model32_", tbl[i].nm}, ref_div(32, tbl[i].s, tbl[i].a32, tbl[i].b32, zz), tbl[i].e32);
      chk({"model16_", tbl[i].nm}, ref_div(16, tbl[i].s, tbl[i].a16, tbl[i].b16, zz), tbl[i].e16);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_status", {61'd0, busy_w[d], done_w[d], dbz_w[d]}, 64'd0);
      chk("reset_data", out_w[d], 64'd0);
    end

    // Directed table on both widths.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        if (d == 0) begin
          launch(d, tbl[i].s, tbl[i].a32, tbl[i].b32);
          await_done(d, tbl[i].e32, tbl[i].z, tbl[i].nm);
        end else begin
          launch(d, tbl[i].s, tbl[i].a16, tbl[i].b16);
          await_done(d, tbl[i].e16, tbl[i].z, tbl[i].nm);
        end
      end
    end

    // Start re-pulsed five cycles into an operation must be ignored.
    for (int d = 0; d < 2; d++) begin
      launch(d, 1'b0, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      st[d] = 1'b1; sg[d] = 1'b1; da[d] = 32'd1000; db[d] = 32'd3;
      @(negedge clk);
      st[d] = 1'b0;
      ev = (d == 0) ? {32'd2, 32'd14} : {32'd0, 16'd2, 16'd14};
      await_done(d, ev, 1'b0, "repulse");
      nd = 0;
      for (int i = 0; i < wid(d) + 6; i++) begin
        @(posedge clk);
        #1;
        if (done_w[d]) nd++;
      end
      chk("repulse_extra_done", 64'(nd), 64'd0);
    end

    // Reset ten cycles into an operation aborts it; the next operation is normal.
    for (int d = 0; d < 2; d++) begin
      launch(d, 1'b0, 32'd5000, 32'd7);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < wid(d) + 6; i++) begin
        @(posedge clk);
        #1;
        if (done_w[d]) nd++;
      end
      chk("abort_no_done", 64'(nd), 64'd0);
      chk("abort_data", out_w[d], 64'd0);
      chk("abort_busy", 64'(busy_w[d]), 64'd0);
      launch(d, 1'b0, 32'd9, 32'd3);
      await_done(d, 64'd3, 1'b0, "after_abort");
    end

    // Randomized traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 799) == 0);
      for (int d = 0; d < 2; d++) begin
        st[d] = ($urandom_range(0, 2) == 0);
        sg[d] = 1'($urandom_range(0, 1));
        da[d] = pick(wid(d));
        db[d] = pick(wid(d));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    st[0] = 1'b0;
    st[1] = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
